// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch_queue IF-stage front end.
package fetch_pkg;

  // Width of PC and instruction words held in a ring entry.
  localparam int XLEN_DEF = 32;

  // PC advance per sequential fetch.
  localparam int INSTR_BYTES = 4;

  // addi x0,x0,0 -- value an entry's instruction slot holds after reset.
  localparam logic [XLEN_DEF-1:0] NOP_INSTR = 32'h0000_0013;

  // One ring slot: fetch address, returned word, and whether the word has arrived.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                rsp_done;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: IF-stage front end between Program_Counter and instruction memory.
// Issues in-order fetches at pc, buffers PC-tagged instructions in a DEPTH-entry
// ring and hands them to decode. A redirect flushes the ring and discards every
// response still outstanding at that moment.
// Optional build macro FETCH_BYPASS_EN: a response arriving while the head slot
// is still waiting is presented to decode in the same cycle.
// Ring slots use fetch_pkg::fetch_entry_t, so XLEN must equal XLEN_DEF.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// imem_req_valid is a fresh offer each cycle and may drop without a transfer;
// if_valid/if_ready is a plain valid/ready pop; imem_rsp_valid cannot be stalled.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_write,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  fetch_entry_t  head_ent;
  logic [PW-1:0] head_q, head_d, req_tail_q, req_tail_d, rsp_tail_q, rsp_tail_d;
  // occ counts allocated-but-unpopped slots, in-flight ones included.
  logic [CW-1:0] occ_q, occ_d, inflight_q, inflight_d, drop_q, drop_d;

  logic credit_ok, req_fire, rsp_keep, rsp_drop, byp_vld, pop, byp_take;

  assign head_ent      = ent_q[head_q];
  assign imem_req_addr = pc;

  // Request offer, PC update, response classification and decode-side view.
  always_comb begin
    credit_ok      = (occ_q + drop_q) < DEPTH_C;
    imem_req_valid = rst & ~redirect_valid & credit_ok;
    req_fire       = imem_req_valid & imem_req_ready;
    pc_write       = rst & (req_fire | redirect_valid);
    next_pc        = (rst & redirect_valid) ? redirect_target : pc + XLEN'(INSTR_BYTES);
    rsp_drop       = imem_rsp_valid & (drop_q != '0);
    rsp_keep       = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
    // Head slot still waiting means rsp_tail == head, so this beat belongs to head.
    byp_vld        = rst & rsp_keep & ~head_ent.rsp_done;
`else
    byp_vld        = 1'b0;
`endif
    if_valid       = rst & ~redirect_valid & (head_ent.rsp_done | byp_vld);
    if_instr       = byp_vld ? imem_rsp_data : head_ent.instr;
    if_pc          = head_ent.pc;
    pop            = if_valid & if_ready;
    byp_take       = byp_vld & if_ready;
  end

  // Next ring contents and pointers; pop, response and request act independently.
  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    req_tail_d = req_tail_q;
    rsp_tail_d = rsp_tail_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Flush: every outstanding response, including one arriving now, gets dropped.
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].rsp_done = 1'b0;
      end
      head_d     = req_tail_q;
      rsp_tail_d = req_tail_q;
      occ_d      = '0;
      inflight_d = '0;
      drop_d     = drop_q + inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (pop) begin
        if (!byp_take) begin
          ent_d[head_q].rsp_done = 1'b0;
        end
        head_d = head_q + 1'b1;
      end
      if (rsp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      if (rsp_keep) begin
        if (!byp_take) begin
          ent_d[rsp_tail_q].instr    = imem_rsp_data;
          ent_d[rsp_tail_q].rsp_done = 1'b1;
        end
        rsp_tail_d = rsp_tail_q + 1'b1;
      end
      if (req_fire) begin
        ent_d[req_tail_q].pc       = pc;
        ent_d[req_tail_q].rsp_done = 1'b0;
        req_tail_d                 = req_tail_q + 1'b1;
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_keep);
      occ_d      = occ_q + CW'(req_fire) - CW'(pop);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      req_tail_q <= '0;
      rsp_tail_q <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].pc       <= '0;
        ent_q[i].instr    <= NOP_INSTR;
        ent_q[i].rsp_done <= 1'b0;
      end
    end else begin
      head_q     <= head_d;
      req_tail_q <= req_tail_d;
      rsp_tail_q <= rsp_tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: Program_Counter model, in-order memory model with
// selectable latency, scoreboard of expected decode PCs, directed phases.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc, next_pc, imem_req_addr, imem_rsp_data, redirect_target, if_instr, if_pc;
  logic        pc_write, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, if_valid, if_ready;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  int          lat = 1;
  int          cyc_r = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  // Clock
  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .next_pc(next_pc), .pc_write(pc_write),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Program_Counter model
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (pc_write) pc <= next_pc;
  end

  // Instruction memory: in order, fixed latency lat, responses lost across reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc_r + lat - 1);
      end
      if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc_r) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= instr_of(mem_addr_q[0]);
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
      cyc_r <= cyc_r + 1;
    end
  end

  // Scoreboard: every decode pop must match the oldest expected PC
  always @(negedge clk) begin
    if (rst) begin
      chk("req_addr_eq_pc", imem_req_addr, pc);
      if (if_valid && if_ready) begin
        chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("pop_pc", if_pc, e);
          chk("pop_instr", if_instr, instr_of(e));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Stop requesting, pop everything, and confirm the ring ends empty
  task automatic drain();
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
    repeat (3) step();
    at_neg();
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_if_valid", 32'(if_valid), 32'd0);
    step();
  endtask

  initial begin
    int cnt;
    imem_req_ready  = 1'b0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // Reset state
    step(); step();
    at_neg();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_next_pc", next_pc, 32'd4);
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    #1;
    chk("rst_redir_pc_write", 32'(pc_write), 32'd0);
    chk("rst_redir_next_pc", next_pc, 32'd4);
    redirect_valid  = 1'b0;
    step();
    rst = 1'b1;

    // Streaming: 1-cycle memory, decode always ready
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk("stream_pc_write", 32'(pc_write), 32'd1);
      chk("stream_pc", pc, 32'(4 * i));
      if (i == 1) chk("stream_fill_valid", 32'(if_valid), 32'd0);
      if (i == 2) begin
        chk("stream_first_valid", 32'(if_valid), 32'd1);
        chk("stream_first_pc", if_pc, 32'd0);
      end
      step();
    end
    drain();

    // Memory not ready: PC holds, next_pc stays pc+4
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall_pc_write", 32'(pc_write), 32'd0);
      chk("stall_pc", pc, 32'd24);
      chk("stall_next_pc", next_pc, 32'd28);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      step();
    end

    // Full ring: exactly DEPTH requests, then hold until a pop frees a slot
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(24 + 4 * i));
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      if (pc_write) cnt++;
      step();
    end
    at_neg();
    chk("full_req_count", 32'(cnt), 32'd4);
    chk("full_pc_hold", pc, 32'd40);
    chk("full_pc_write", 32'(pc_write), 32'd0);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_if_valid", 32'(if_valid), 32'd1);
    chk("full_if_pc", if_pc, 32'd24);
    step();
    if_ready = 1'b1;
    at_neg();
    chk("full_pop_cycle_pc_write", 32'(pc_write), 32'd0);
    step();
    if_ready = 1'b0;
    at_neg();
    chk("full_after_pop_pc_write", 32'(pc_write), 32'd1);
    chk("full_after_pop_pc", pc, 32'd40);
    step();
    drain();

    // Redirect with two requests in flight (3-cycle memory)
    lat = 3;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    at_neg();
    chk("redir_d0_pc", pc, 32'd44);
    step();
    at_neg();
    chk("redir_d1_pc", pc, 32'd48);
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    at_neg();
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    chk("redir_pc_write", 32'(pc_write), 32'd1);
    chk("redir_next_pc", next_pc, 32'h100);
    chk("redir_if_valid", 32'(if_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    at_neg();
    chk("redir_d3_pc", pc, 32'h100);
    chk("redir_d3_if_valid", 32'(if_valid), 32'd0);
    step();
    at_neg();
    chk("redir_d4_pc", pc, 32'h104);
    chk("redir_d4_if_valid", 32'(if_valid), 32'd0);
    step();
    drain();

    // Redirect colliding with a response and a decode pop (1-cycle memory)
    lat = 1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    at_neg();
    chk("coll_f0_pc", pc, 32'h108);
    step();
    at_neg();
    chk("coll_f1_if_valid", 32'(if_valid), 32'd0);
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    at_neg();
    chk("coll_if_valid", 32'(if_valid), 32'd0);
    chk("coll_pc_write", 32'(pc_write), 32'd1);
    step();
    redirect_valid = 1'b0;
    at_neg();
    chk("coll_f3_pc", pc, 32'h200);
    step();
    at_neg();
    chk("coll_f4_pc", pc, 32'h204);
    step();
    drain();

    // Asynchronous reset with three entries buffered
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    repeat (3) step();
    imem_req_ready = 1'b0;
    step();
    at_neg();
    chk("arst_pre_if_valid", 32'(if_valid), 32'd1);
    chk("arst_pre_if_pc", if_pc, 32'h208);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_if_valid", 32'(if_valid), 32'd0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    step(); step();
    rst = 1'b1;
    at_neg();
    chk("arst_rel_if_valid", 32'(if_valid), 32'd0);
    chk("arst_rel_pc", pc, 32'd0);
    chk("arst_rel_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    step();
    step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
